// File: rtl/cvxif_reg_buffer.sv
// rtl/cvxif_reg_buffer.sv - append-register bank with status flags and in-order valid/ready drain port
// Optional feature macro: CVXIF_REG_BUFFER_WRAP_EN (overwrite oldest entry when full, drain from oldest)
module cvxif_reg_buffer #(
    parameter  int NB_REGS     = 150,
    parameter  int REG_WIDTH   = 9,
    parameter  int OUT_WIDTH   = 16,
    parameter  int SIGNED_REGS = 0,
    localparam int PTR_W       = $clog2(NB_REGS + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               dump_i,
    input  logic                               we_i,
    input  logic [REG_WIDTH-1:0]               wb_data_i,
    input  logic                               drain_i,
    output logic                               rd_valid_o,
    input  logic                               rd_ready_i,
    output logic [OUT_WIDTH-1:0]               rd_data_o,
    output logic                               rd_last_o,
    output logic                               busy_o,
    output logic [PTR_W-1:0]                   count_o,
    output logic                               full_o,
    output logic                               overflow_o,
    output logic [NB_REGS-1:0][REG_WIDTH-1:0]  regs_o
);

    localparam int               IDX_W    = $clog2(NB_REGS);
    localparam logic [PTR_W-1:0] NB_P     = PTR_W'(NB_REGS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NB_REGS - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [REG_WIDTH-1:0]   mem_q [NB_REGS];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_nxt, count_q;
    logic [PTR_W-1:0]       rd_ptr_q, rd_idx_q, drain_len_q, start_idx;
    logic                   overflow_q;
    logic                   full, start_drain, handshake, last_beat;

    // Sign- or zero-extend one stored entry to the drain width
    function automatic logic [OUT_WIDTH-1:0] extend(input logic [REG_WIDTH-1:0] v);
        logic [OUT_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (i < REG_WIDTH)
                r[i] = v[i];
            else
                r[i] = (SIGNED_REGS != 0) ? v[REG_WIDTH-1] : 1'b0;
        end
        return r;
    endfunction

    assign full        = (count_q == NB_P);
    assign start_drain = (state_q == IDLE) && drain_i && (count_q != '0) && !dump_i;
    assign handshake   = (state_q == DRAIN) && rd_ready_i;
    assign last_beat   = (rd_ptr_q == drain_len_q - PTR_W'(1));

`ifdef CVXIF_REG_BUFFER_WRAP_EN
    // Once the bank has wrapped, wr_ptr points at the oldest entry
    assign wr_ptr_nxt = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
    assign start_idx  = full ? wr_ptr_q : '0;
`else
    assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    assign start_idx  = '0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: dump aborts a drain, last accepted beat ends it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_drain) state_d = DRAIN;
            DRAIN:   if (dump_i || (handshake && last_beat)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: drain data is presented straight from the bank at the read index
    always_comb begin
        rd_valid_o = (state_q == DRAIN);
        busy_o     = (state_q == DRAIN);
        rd_last_o  = (state_q == DRAIN) && last_beat;
        rd_data_o  = (state_q == DRAIN) ? extend(mem_q[rd_idx_q[IDX_W-1:0]]) : '0;
    end

    // Append path: entries, write pointer, occupancy and sticky overflow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB_REGS; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (dump_i) begin
            for (int i = 0; i < NB_REGS; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (we_i) begin
            if (!full) begin
                mem_q[wr_ptr_q[IDX_W-1:0]] <= wb_data_i;
                wr_ptr_q <= wr_ptr_nxt;
                count_q  <= count_q + PTR_W'(1);
            end else begin
`ifdef CVXIF_REG_BUFFER_WRAP_EN
                mem_q[wr_ptr_q[IDX_W-1:0]] <= wb_data_i;
                wr_ptr_q <= wr_ptr_nxt;
`endif
                overflow_q <= 1'b1;
            end
        end
    end

    // Drain path: beat counter, wrapping read index and length latched at start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q    <= '0;
            rd_idx_q    <= '0;
            drain_len_q <= '0;
        end else if (dump_i) begin
            rd_ptr_q    <= '0;
            rd_idx_q    <= '0;
            drain_len_q <= '0;
        end else if (start_drain) begin
            rd_ptr_q    <= '0;
            rd_idx_q    <= start_idx;
            drain_len_q <= count_q;
        end else if (handshake) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + PTR_W'(1);
        end
    end

    assign count_o    = count_q;
    assign full_o     = full;
    assign overflow_o = overflow_q;

    // Parallel view of the whole bank
    for (genvar g = 0; g < NB_REGS; g++) begin : g_regs
        assign regs_o[g] = mem_q[g];
    end

endmodule

// File: tb/tb_cvxif_reg_buffer.sv
// tb/tb_cvxif_reg_buffer.sv - directed self-checking bench for cvxif_reg_buffer
module tb_cvxif_reg_buffer;

    logic clk, rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Group A: shared stimulus into a signed and a zero-extending instance
    logic        a_dump, a_we, a_drain, a_ready;
    logic [8:0]  a_data;
    logic        s_valid, s_last, s_busy, s_full, s_ovf;
    logic [15:0] s_rdata;
    logic [7:0]  s_count;
    logic [149:0][8:0] s_regs;
    logic        z_valid, z_last, z_busy, z_full, z_ovf;
    logic [15:0] z_rdata;
    logic [7:0]  z_count;
    logic [149:0][8:0] z_regs;

    // Group C: four-entry instance for full/overflow behaviour
    logic        c_dump, c_we, c_drain, c_ready;
    logic [8:0]  c_data;
    logic        c_valid, c_last, c_busy, c_full, c_ovf;
    logic [15:0] c_rdata;
    logic [2:0]  c_count;
    logic [3:0][8:0] c_regs;

    cvxif_reg_buffer #(.NB_REGS(150), .REG_WIDTH(9), .OUT_WIDTH(16), .SIGNED_REGS(1)) u_s (
        .clk_i(clk), .rst_i(rst), .dump_i(a_dump), .we_i(a_we), .wb_data_i(a_data),
        .drain_i(a_drain), .rd_valid_o(s_valid), .rd_ready_i(a_ready), .rd_data_o(s_rdata),
        .rd_last_o(s_last), .busy_o(s_busy), .count_o(s_count), .full_o(s_full),
        .overflow_o(s_ovf), .regs_o(s_regs));

    cvxif_reg_buffer #(.NB_REGS(150), .REG_WIDTH(9), .OUT_WIDTH(16), .SIGNED_REGS(0)) u_z (
        .clk_i(clk), .rst_i(rst), .dump_i(a_dump), .we_i(a_we), .wb_data_i(a_data),
        .drain_i(a_drain), .rd_valid_o(z_valid), .rd_ready_i(a_ready), .rd_data_o(z_rdata),
        .rd_last_o(z_last), .busy_o(z_busy), .count_o(z_count), .full_o(z_full),
        .overflow_o(z_ovf), .regs_o(z_regs));

    cvxif_reg_buffer #(.NB_REGS(4), .REG_WIDTH(9), .OUT_WIDTH(16), .SIGNED_REGS(0)) u_c (
        .clk_i(clk), .rst_i(rst), .dump_i(c_dump), .we_i(c_we), .wb_data_i(c_data),
        .drain_i(c_drain), .rd_valid_o(c_valid), .rd_ready_i(c_ready), .rd_data_o(c_rdata),
        .rd_last_o(c_last), .busy_o(c_busy), .count_o(c_count), .full_o(c_full),
        .overflow_o(c_ovf), .regs_o(c_regs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [8:0] v);
        a_we = 1'b1; a_data = v;
        tick();
        a_we = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (s_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", s_count); end
        n_tests++; if (s_full !== 1'b0 || s_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got full=%b ovf=%b want 0 0", s_full, s_ovf); end
        n_tests++; if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_last !== 1'b0) begin n_fail++; $display("FAIL reset_fsm got valid=%b busy=%b last=%b want 0 0 0", s_valid, s_busy, s_last); end
        n_tests++; if (s_rdata !== 16'h0 || s_regs[0] !== 9'h0) begin n_fail++; $display("FAIL reset_data got rdata=%h reg0=%h want 0 0", s_rdata, s_regs[0]); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_append();
        write_a(9'h1FF); write_a(9'h003); write_a(9'h100);
        n_tests++; if (s_count !== 8'd3) begin n_fail++; $display("FAIL append_count got %0d want 3", s_count); end
        n_tests++; if (s_regs[0] !== 9'h1FF || s_regs[1] !== 9'h003 || s_regs[2] !== 9'h100)
            begin n_fail++; $display("FAIL append_regs got %h %h %h want 1ff 003 100", s_regs[0], s_regs[1], s_regs[2]); end
        n_tests++; if (s_full !== 1'b0 || s_ovf !== 1'b0) begin n_fail++; $display("FAIL append_flags got full=%b ovf=%b want 0 0", s_full, s_ovf); end
    endtask

    task automatic test_drain_ext();
        logic [15:0] exp_s [3] = '{16'hFFFF, 16'h0003, 16'hFF00};
        logic [15:0] exp_z [3] = '{16'h01FF, 16'h0003, 16'h0100};
        a_ready = 1'b1; a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (s_valid !== 1'b1 || z_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid beat %0d got %b %b want 1", i, s_valid, z_valid); end
            n_tests++; if (s_rdata !== exp_s[i]) begin n_fail++; $display("FAIL drain_signed beat %0d got %h want %h", i, s_rdata, exp_s[i]); end
            n_tests++; if (z_rdata !== exp_z[i]) begin n_fail++; $display("FAIL drain_zero beat %0d got %h want %h", i, z_rdata, exp_z[i]); end
            n_tests++; if (s_last !== (i == 2)) begin n_fail++; $display("FAIL drain_last beat %0d got %b want %b", i, s_last, (i == 2)); end
            tick();
        end
        n_tests++; if (s_busy !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end got busy=%b valid=%b want 0 0", s_busy, s_valid); end
        n_tests++; if (s_count !== 8'd3 || s_regs[1] !== 9'h003) begin n_fail++; $display("FAIL drain_nondestructive got count=%0d reg1=%h want 3 003", s_count, s_regs[1]); end
    endtask

    task automatic test_back_to_back_stall();
        logic [15:0] exp_s [3] = '{16'hFFFF, 16'h0003, 16'hFF00};
        logic        pat [5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int beat = 0;
        a_drain = 1'b1; a_ready = 1'b0;
        tick();
        a_drain = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_ready = pat[k];
            a_we    = (k == 1);
            a_data  = 9'h055;
            n_tests++; if (s_valid !== 1'b1 || s_rdata !== exp_s[beat]) begin n_fail++; $display("FAIL stall_data cycle %0d got valid=%b data=%h want 1 %h", k, s_valid, s_rdata, exp_s[beat]); end
            n_tests++; if (s_last !== (beat == 2)) begin n_fail++; $display("FAIL stall_last cycle %0d got %b want %b", k, s_last, (beat == 2)); end
            if (s_valid && a_ready) beat++;
            tick();
        end
        a_we = 1'b0;
        n_tests++; if (beat !== 3 || s_busy !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end got beats=%0d busy=%b valid=%b want 3 0 0", beat, s_busy, s_valid); end
        n_tests++; if (s_count !== 8'd4 || s_regs[3] !== 9'h055) begin n_fail++; $display("FAIL stall_write got count=%0d reg3=%h want 4 055", s_count, s_regs[3]); end
    endtask

    task automatic test_dump_mid_drain();
        a_ready = 1'b1; a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        tick();
        a_dump = 1'b1; a_we = 1'b1; a_data = 9'h0AA;
        tick();
        a_dump = 1'b0; a_we = 1'b0;
        n_tests++; if (s_count !== 8'd0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL dump_state got count=%0d valid=%b busy=%b want 0 0 0", s_count, s_valid, s_busy); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (s_regs[i] !== 9'h0) begin n_fail++; $display("FAIL dump_entry %0d got %h want 000", i, s_regs[i]); end
        end
        n_tests++; if (s_ovf !== 1'b0 || s_full !== 1'b0) begin n_fail++; $display("FAIL dump_flags got ovf=%b full=%b want 0 0", s_ovf, s_full); end
    endtask

    task automatic test_drain_empty();
        c_drain = 1'b1;
        tick();
        c_drain = 1'b0;
        n_tests++; if (c_busy !== 1'b0 || c_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got busy=%b valid=%b want 0 0", c_busy, c_valid); end
    endtask

    task automatic test_full_overflow();
`ifdef CVXIF_REG_BUFFER_WRAP_EN
        logic [8:0] exp_r [4] = '{9'd5, 9'd2, 9'd3, 9'd4};
        logic [8:0] exp_d [4] = '{9'd2, 9'd3, 9'd4, 9'd5};
`else
        logic [8:0] exp_r [4] = '{9'd1, 9'd2, 9'd3, 9'd4};
        logic [8:0] exp_d [4] = '{9'd1, 9'd2, 9'd3, 9'd4};
`endif
        for (int v = 1; v <= 5; v++) begin
            c_we = 1'b1; c_data = 9'(v);
            tick();
            if (v == 4) begin
                n_tests++; if (c_full !== 1'b1 || c_ovf !== 1'b0) begin n_fail++; $display("FAIL full_at4 got full=%b ovf=%b want 1 0", c_full, c_ovf); end
            end
        end
        c_we = 1'b0;
        n_tests++; if (c_ovf !== 1'b1 || c_count !== 3'd4 || c_full !== 1'b1) begin n_fail++; $display("FAIL overflow got ovf=%b count=%0d full=%b want 1 4 1", c_ovf, c_count, c_full); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (c_regs[i] !== exp_r[i]) begin n_fail++; $display("FAIL full_regs %0d got %h want %h", i, c_regs[i], exp_r[i]); end
        end
        c_ready = 1'b1; c_drain = 1'b1;
        tick();
        c_drain = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (c_valid !== 1'b1 || c_rdata !== 16'(exp_d[i])) begin n_fail++; $display("FAIL full_drain beat %0d got valid=%b data=%h want 1 %h", i, c_valid, c_rdata, 16'(exp_d[i])); end
            n_tests++; if (c_last !== (i == 3)) begin n_fail++; $display("FAIL full_last beat %0d got %b want %b", i, c_last, (i == 3)); end
            tick();
        end
        n_tests++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL full_drain_end got busy=%b want 0", c_busy); end
    endtask

    task automatic test_async_reset();
        write_a(9'h011); write_a(9'h122);
        a_ready = 1'b0; a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        n_tests++; if (s_valid !== 1'b1 || s_rdata !== 16'h0011) begin n_fail++; $display("FAIL areset_pre got valid=%b data=%h want 1 0011", s_valid, s_rdata); end
        #3 rst = 1'b1;
        #1;
        n_tests++; if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_rdata !== 16'h0 || s_last !== 1'b0) begin n_fail++; $display("FAIL areset_fsm got valid=%b busy=%b data=%h last=%b want 0 0 0 0", s_valid, s_busy, s_rdata, s_last); end
        n_tests++; if (s_count !== 8'd0 || s_regs[0] !== 9'h0 || s_regs[1] !== 9'h0) begin n_fail++; $display("FAIL areset_bank got count=%0d reg0=%h reg1=%h want 0 0 0", s_count, s_regs[0], s_regs[1]); end
        #1 rst = 1'b0;
        a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        n_tests++; if (s_busy !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL areset_drain_empty got busy=%b valid=%b want 0 0", s_busy, s_valid); end
    endtask

    initial begin
        rst = 1'b1;
        a_dump = 0; a_we = 0; a_drain = 0; a_ready = 0; a_data = '0;
        c_dump = 0; c_we = 0; c_drain = 0; c_ready = 0; c_data = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_append();
        test_drain_ext();
        test_back_to_back_stall();
        test_dump_mid_drain();
        test_drain_empty();
        test_full_overflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cvxif_reg_buffer.md
Name: cvxif_reg_buffer

Overview:
- Parametrised successor to the team's non-addressed CVXIF append-register bank.
- Writes append at an internal pointer; the full bank is exposed in parallel.
- Adds occupancy/full/sticky-overflow status and a valid/ready drain port that streams stored entries in order, sign- or zero-extended to OUT_WIDTH.
- Sits between the CVXIF coprocessor writeback path and downstream consumers.

Parameters:
NB_REGS, 150, number of entries (>=2)
REG_WIDTH, 9, bits per entry
OUT_WIDTH, 16, drain data width (>= REG_WIDTH)
SIGNED_REGS, 0, 1: drain data sign-extended; 0: zero-extended
PTR_W (localparam), $clog2(NB_REGS+1), width of pointers and count

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
dump_i  in  1  synchronous clear of entries, pointers and flags
we_i  in  1  append wb_data_i this cycle
wb_data_i  in  REG_WIDTH  data to append
drain_i  in  1  start-drain request pulse (honoured only in IDLE)
rd_valid_o  out  1  drain data valid
rd_ready_i  in  1  consumer accepts drain data
rd_data_o  out  OUT_WIDTH  extended entry at drain pointer
rd_last_o  out  1  current drain beat is the final one
busy_o  out  1  high while in DRAIN
count_o  out  PTR_W  number of stored entries
full_o  out  1  count_o == NB_REGS
overflow_o  out  1  sticky: a write was dropped
regs_o  out  NB_REGS x REG_WIDTH  parallel view of all entries

Behaviour:
- Reset (rst_i async assert): all entries 0, wr_ptr=0, count_o=0, full_o=0, overflow_o=0, FSM=IDLE, rd_valid_o=0, rd_last_o=0, busy_o=0, rd_data_o=0.
- dump_i: the same clear, applied at the next clock edge; it has priority over we_i and drain_i in the same cycle. In DRAIN it aborts the drain: return to IDLE and deassert rd_valid_o the next cycle.
- Write, we_i && !dump_i:
  - not full: entry[wr_ptr] <= wb_data_i; wr_ptr and count_o increment; regs_o reflects the new value next cycle.
  - full: data dropped, entries unchanged, overflow_o <= 1 (held until dump/reset).
- Writes are accepted in both IDLE and DRAIN.
- FSM states: IDLE and DRAIN.
  - IDLE -> DRAIN on drain_i && count_o>0 && !dump_i: latch drain_len=count_o and set rd_ptr=0.
  - drain_i with count_o==0 is ignored.
  - drain_i while in DRAIN is ignored.
- DRAIN:
  - rd_valid_o=1; rd_data_o = extend(entry[rd_ptr]) combinationally from state.
  - rd_last_o = (rd_ptr == drain_len-1).
  - Handshake (rd_valid_o && rd_ready_i) advances rd_ptr.
  - Handshake on the last beat returns to IDLE the next cycle.
  - rd_data_o is held stable while rd_valid_o && !rd_ready_i.
  - Entries appended during a drain are not streamed; drain length is fixed at start.
- Draining is non-destructive: entries and count_o are unchanged by a drain.
- Extension: SIGNED_REGS=1 replicates bit REG_WIDTH-1; SIGNED_REGS=0 pads with zeros.
- Throughput: one beat per cycle under continuous rd_ready_i. First rd_valid_o appears 1 cycle after the accepted drain_i.

Optional Feature:
- Macro CVXIF_REG_BUFFER_WRAP_EN.
- Defined: write when full overwrites entry[wr_ptr] with wr_ptr wrapping NB_REGS-1 -> 0; count_o saturates at NB_REGS; overflow_o still sets on the first overwrite. The drain then starts at the oldest entry, wr_ptr, and wraps modulo NB_REGS.
- Undefined: drop-on-full behaviour as above; drain always starts at index 0.

Test Plan:
- Reset then append 0x1FF, 0x003, 0x100 -> count_o=3; regs_o[0..2]=0x1FF,0x003,0x100; full_o=0; overflow_o=0.
- SIGNED_REGS=1, OUT_WIDTH=16, drain_i with rd_ready_i=1 -> 3 beats 0xFFFF, 0x0003, 0xFF00; rd_last_o on 3rd beat; busy_o low after. Repeat with SIGNED_REGS=0 -> 0x01FF, 0x0003, 0x0100.
- NB_REGS=4: write 5 values 1..5 -> full_o=1 after 4th; overflow_o=1; regs_o=1,2,3,4. With CVXIF_REG_BUFFER_WRAP_EN: regs_o=5,2,3,4; drain yields 2,3,4,5.
- Drain with rd_ready_i toggling 1,0,0,1,1 while writing one new value -> rd_data_o stable during stalls; exactly drain_len beats; count_o increments by 1.
- dump_i and we_i asserted together mid-drain -> next cycle count_o=0, rd_valid_o=0, busy_o=0, all entries 0, written data discarded.
- Assert rst_i asynchronously between clock edges mid-drain -> outputs reach reset values without a clock edge; drain_i with count_o=0 afterwards leaves busy_o=0.
